// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: 16-bit shift-add multiply / restoring divide sequencer driving an external ALU; optional Abort input via SEQ_ABORT_EN.
module alu_seq_muldiv #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SEQ_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_a_invert,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry_out,
  input  logic             alu_zero,
  input  logic             alu_overflow
);
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b1100;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_d;
  logic [WIDTH-1:0] hi, lo, m, nxt_hi, nxt_lo;
  logic [CNT_W-1:0] cnt;
  logic mode_r, ge, abort_i, accept, div0, last, unused_flags;
`ifdef SEQ_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif
  assign unused_flags = alu_zero ^ alu_overflow;
  assign busy = state == RUN;
  assign done = state == DONE;
  assign alu_a_invert = 1'b0;
  assign accept = state == IDLE && start;
  assign div0 = mode && op_b == '0;
  assign last = cnt == CNT_W'(WIDTH - 1);
  always_comb begin
    alu_a = '0;
    alu_b = '0;
    alu_op = OP_ADD;
    if (busy && mode_r) begin
      alu_a = {hi[WIDTH-2:0], lo[WIDTH-1]};
      alu_b = m;
      alu_op = OP_SUB;
    end else if (busy && lo[0]) begin
      alu_a = hi;
      alu_b = m;
    end
  end
  // R[15] set means the shifted remainder already exceeds any 16-bit divisor
  assign ge = hi[WIDTH-1] | alu_carry_out;
  assign nxt_hi = mode_r ? (ge ? alu_result : alu_a)
                         : (lo[0] ? {alu_carry_out, alu_result[WIDTH-1:1]} : {1'b0, hi[WIDTH-1:1]});
  assign nxt_lo = mode_r ? {lo[WIDTH-2:0], ge}
                         : {lo[0] ? alu_result[0] : hi[0], lo[WIDTH-1:1]};
  always_comb begin
    state_d = state;
    if (accept) state_d = div0 ? DONE : RUN;
    else if (busy) state_d = abort_i ? IDLE : (last ? DONE : RUN);
    else if (done) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
      m <= '0;
      cnt <= '0;
      mode_r <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      mode_r <= mode;
      cnt <= '0;
      if (div0) begin
        result_lo <= '1;
        result_hi <= op_a;
        div_by_zero <= 1'b1;
      end else begin
        hi <= '0;
        lo <= mode ? op_a : op_b;
        m <= mode ? op_b : op_a;
        div_by_zero <= mode ? 1'b0 : div_by_zero;
      end
    end else if (busy && !abort_i) begin
      hi <= nxt_hi;
      lo <= nxt_lo;
      cnt <= cnt + CNT_W'(1);
      if (last) begin
        result_hi <= nxt_hi;
        result_lo <= nxt_lo;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq_muldiv.sv
// tb_alu_seq_muldiv: scoreboard bench with a behavioural ALU16 model for alu_seq_muldiv.
module tb_alu_seq_muldiv;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0, abort = 1'b0;
  logic [15:0] op_a = '0, op_b = '0;
  logic busy, done, div_by_zero, alu_a_invert, alu_carry_out, alu_zero, alu_overflow;
  logic [15:0] result_lo, result_hi, alu_a, alu_b, alu_result;
  logic [3:0] alu_op;
  int total = 0, bad = 0, cyc = 0, busy_cnt = 0;
  typedef struct {
    logic [15:0] lo, hi;
    logic dbz;
    int lat, bcyc, scyc;
  } exp_t;
  exp_t sb[$];

  alu_seq_muldiv dut (
    .clk(clk), .rst_n(rst_n),
`ifdef SEQ_ABORT_EN
    .abort(abort),
`endif
    .start(start), .mode(mode), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
    .div_by_zero(div_by_zero), .alu_a(alu_a), .alu_b(alu_b), .alu_a_invert(alu_a_invert),
    .alu_op(alu_op), .alu_result(alu_result), .alu_carry_out(alu_carry_out),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow)
  );

  // reference ALU16: ADD and SUB (a + ~b + 1, carry = no borrow)
  always_comb begin
    if (alu_op == 4'b1100) {alu_carry_out, alu_result} = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
    else {alu_carry_out, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
    alu_zero = alu_result == 16'h0;
    alu_overflow = 1'b0;
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst_n) busy_cnt = 0;
    else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("result_lo", {16'h0, result_lo}, {16'h0, e.lo});
          check("result_hi", {16'h0, result_hi}, {16'h0, e.hi});
          check("div_by_zero", {31'h0, div_by_zero}, {31'h0, e.dbz});
          check("latency", cyc - e.scyc + 1, e.lat);
          check("busy_cycles", busy_cnt, e.bcyc);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input logic md, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] lo, input logic [15:0] hi, input logic dbz, input bit push);
    exp_t e;
    int n = 0;
    while ((busy || done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    mode = md;
    op_a = a;
    op_b = b;
    if (push) begin
      e.lo = lo;
      e.hi = hi;
      e.dbz = dbz;
      e.lat = (md && b == 16'h0) ? 1 : 17;
      e.bcyc = (md && b == 16'h0) ? 0 : 16;
      e.scyc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    op_a = 16'($urandom);
    op_b = 16'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy || done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #12;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_lo_hi", {result_hi, result_lo}, 32'h0);
    check("rst_dbz", {31'h0, div_by_zero}, 32'h0);
    check("rst_alu", {alu_a, alu_b}, 32'h0);
    check("rst_alu_op", {28'h0, alu_op}, 32'h4);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(1'b0, 16'd100, 16'd85, 16'h2134, 16'h0000, 1'b0, 1'b1);
    drain();
    issue(1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b1);
    issue(1'b0, 16'h1234, 16'h0010, 16'h2340, 16'h0001, 1'b0, 1'b1);
    issue(1'b1, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b1);
    issue(1'b1, 16'hFFFF, 16'h8001, 16'h0001, 16'h7FFE, 1'b0, 1'b1);
    issue(1'b1, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b1);
    issue(1'b1, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b1);
    issue(1'b1, 16'd50, 16'd5, 16'd10, 16'd0, 1'b0, 1'b1);
    issue(1'b0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b1);
    drain();
    check("idle_alu_op", {28'h0, alu_op}, 32'h4);
    check("idle_alu_a", {16'h0, alu_a}, 32'h0);
    check("alu_a_invert", {31'h0, alu_a_invert}, 32'h0);
    // start pulses during RUN and in the DONE cycle must be dropped
    issue(1'b0, 16'd3, 16'd5, 16'd15, 16'd0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b1; mode = 1'b1; op_a = 16'd9; op_b = 16'd0;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 40 && !done; n++) @(negedge clk);
    start = 1'b1; mode = 1'b1; op_a = 16'd9; op_b = 16'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("ignored_hold_lo", {16'h0, result_lo}, 32'd15);
    // async reset at iteration 8 aborts with no Done
    issue(1'b0, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'h0, busy}, 32'h0);
    check("arst_done", {31'h0, done}, 32'h0);
    check("arst_lo_hi", {result_hi, result_lo}, 32'h0);
    check("arst_dbz", {31'h0, div_by_zero}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    issue(1'b1, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b1);
    drain();
`ifdef SEQ_ABORT_EN
    issue(1'b0, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", {31'h0, busy}, 32'h0);
    repeat (25) @(negedge clk);
    check("abort_hold", {result_hi, result_lo}, {16'd2, 16'd14});
    check("abort_dbz", {31'h0, div_by_zero}, 32'h0);
`endif
    check("queue_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_seq_muldiv.md
Name: alu_seq_muldiv

Overview:
- Multi-cycle initiator for the 16-bit combinational ALU. It is the operand/opcode driver and the flag consumer on the ALU's interface.
- Performs unsigned 16x16 multiply (shift-add) and unsigned 16/16 divide (restoring), one ALU add/sub per clock.
- Sits between the control unit (Start/Mode handshake) and an externally instantiated ALU16. All arithmetic goes through the ALU port.

Parameters:
- WIDTH, 16, operand width; fixed to the ALU width, no other value supported.
- CNT_W, 5, iteration counter width; must hold WIDTH.

Ports:
- Clock  in  1  single system clock, rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- Start  in  1  request; sampled only in IDLE.
- Mode  in  1  0 = multiply, 1 = divide; sampled with Start.
- OpA  in  16  multiplicand / dividend.
- OpB  in  16  multiplier / divisor.
- Busy  out  1  high in RUN.
- Done  out  1  one-cycle pulse when results are valid.
- ResultLo  out  16  product[15:0] / quotient.
- ResultHi  out  16  product[31:16] / remainder.
- DivByZero  out  1  set when the last divide had OpB = 0.
- AluA  out  16  ALU A operand.
- AluB  out  16  ALU B operand.
- AluAInvert  out  1  tied 0.
- AluOp  out  4  4'b0100 ADD, 4'b1100 SUB.
- AluResult  in  16  ALU result.
- AluCarryOut  in  1  ALU carry; for SUB, 1 = no borrow.
- AluZero  in  1  unused; a flag input only.
- AluOverflow  in  1  unused; a flag input only.

Behaviour:
- Reset (async, ResetN = 0):
  - State = IDLE; counter = 0.
  - Busy, Done, DivByZero = 0; ResultLo, ResultHi = 0.
  - Internal registers = 0.
  - Reset mid-RUN aborts immediately with no Done.
- States: IDLE, RUN, DONE.
- IDLE, with Start = 1 at edge N:
  - Multiply: P_hi = 0, P_lo = OpB, M = OpA, counter = 0. Go to RUN.
  - Divide with OpB != 0: R = 0, Q = OpA, D = OpB, counter = 0, DivByZero = 0. Go to RUN.
  - Divide with OpB = 0: ResultLo = 16'hFFFF, ResultHi = OpA, DivByZero = 1. Go to DONE directly; Done is high in cycle N+1.
- RUN: one iteration per edge; edges N+1 through N+16.
  - Multiply:
    - If P_lo[0] = 1: AluA = P_hi, AluB = M, AluOp = ADD. Next {P_hi, P_lo} = {AluCarryOut, AluResult, P_lo[15:1]}.
    - Else: next {P_hi, P_lo} = {1'b0, P_hi, P_lo[15:1]}.
  - Divide:
    - AluA = {R[14:0], Q[15]}, AluB = D, AluOp = SUB.
    - ge = R[15] | AluCarryOut.
    - If ge: R = AluResult and Q = {Q[14:0], 1}.
    - Else: R = AluA and Q = {Q[14:0], 0}.
  - Counter increments each edge. At the edge where counter = 15, the final values go to ResultHi/ResultLo and the state goes to DONE.
- DONE: Done = 1 for exactly one cycle (cycle N+17), then back to IDLE.
- Latency: Start edge to Done is 17 cycles; divide-by-zero takes 1 cycle.
- Results and DivByZero hold until the next accepted Start.
- Start while Busy or in DONE: ignored; no queueing.
- Start in the same cycle that Done is high: ignored. The new request must be presented in IDLE.
- ALU drive when not in a multiply add-step or divide step: AluA = 0, AluB = 0, AluOp = ADD.
- OpA and OpB are needed only at the Start edge and may change afterwards.

Optional Feature:
- Macro: SEQ_ABORT_EN.
- Defined:
  - Adds input port Abort (1 bit).
  - Abort = 1 in RUN: the next edge goes to IDLE, Busy falls, and no Done is produced.
  - ResultLo, ResultHi and DivByZero keep their previous values.
  - Abort has no effect in IDLE or DONE.
- Undefined: no Abort port; every accepted operation runs to completion.

Test Plan:
- Mul OpA = 100, OpB = 85 -> Done in cycle N+17; ResultHi = 16'h0000, ResultLo = 16'h2134 (8500); Busy high for 16 cycles.
- Mul OpA = OpB = 16'hFFFF -> ResultHi = 16'hFFFE, ResultLo = 16'h0001; AluCarryOut propagated into P_hi.
- Div OpA = 100, OpB = 7 -> ResultLo = 14, ResultHi = 2, DivByZero = 0.
- Div OpA = 16'hFFFF, OpB = 16'h8001 -> ResultLo = 1, ResultHi = 16'h7FFE (exercises the R[15] = 1 path). Div OpA = 16'hFFFF, OpB = 1 -> ResultLo = 16'hFFFF, ResultHi = 0.
- Div OpB = 0, OpA = 16'h1234 -> Done in cycle N+1; ResultLo = 16'hFFFF, ResultHi = 16'h1234, DivByZero = 1. A following valid divide clears DivByZero.
- Start pulses during RUN -> ignored, results unchanged. ResetN low at iteration 8 -> all outputs 0 asynchronously and no Done. With SEQ_ABORT_EN, Abort at iteration 5 -> IDLE, no Done, old results held.
